fwft_fifo_sync: RTL and testbench

//  Single-clock first-word-fall-through FIFO; parametrised successor of the dual-clock FWFT FIFO.

---
 rtl/fwft_fifo_sync_if.sv | 30 +++
 rtl/fwft_fifo_sync.sv | 171 +++++++++++++++++
 tb/tb_fwft_fifo_sync.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fwft_fifo_sync_if.sv
// Handshake bundle for the single-clock FWFT FIFO: write side, read side,
// flush, fill-level and sticky error status.
interface fwft_fifo_sync_if #(
  parameter int NBITS      = 64,
  parameter int DEPTH_LOG2 = 9
);
  logic [NBITS-1:0]    i_data;
  logic                i_valid;
  logic                i_ready;
  logic                i_flush;
  logic [NBITS-1:0]    o_data;
  logic                o_valid;
  logic                o_read;
  logic                o_almost_empty;
  logic [DEPTH_LOG2:0] o_count;
  logic                o_overflow;
  logic                o_underflow;

  // Producer/consumer side that drives the FIFO.
  modport master (
    output i_data, i_valid, i_flush, o_read,
    input  i_ready, o_data, o_valid, o_almost_empty, o_count, o_overflow, o_underflow
  );

  // The FIFO itself.
  modport slave (
    input  i_data, i_valid, i_flush, o_read,
    output i_ready, o_data, o_valid, o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/fwft_fifo_sync.sv
// Single-clock first-word-fall-through FIFO.
// RAM storage with DEPTH_LOG2+1-bit pointers (MSB separates full from empty),
// followed by two output register stages A -> B; B is the visible head word.
// Writes to a full RAM are dropped and flagged; reads while empty are ignored
// and flagged. i_flush synchronously empties the FIFO and clears the flags.
module fwft_fifo_sync #(
  parameter int NBITS      = 64,
  parameter int DEPTH_LOG2 = 9,
  parameter int AF_MARGIN  = 64,
  parameter int AE_THRESH  = 15
) (
  input  logic            clock,
  input  logic            reset_n,
  fwft_fifo_sync_if.slave bus
);

  localparam int                  PW      = DEPTH_LOG2 + 1;
  localparam int                  DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [PW-1:0]       DEPTH_C = PW'(DEPTH);
  localparam logic [PW-1:0]       AF_C    = PW'(AF_MARGIN);
  localparam logic [31:0]         AE_C    = 32'(AE_THRESH);

  logic [NBITS-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             a_v_q, a_v_d;
  logic             b_v_q, b_v_d;
  logic [NBITS-1:0] a_data_q;
  logic [NBITS-1:0] b_data_q;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             i_ready_q, i_ready_d;
  logic             ae_q, ae_d;
  logic [PW-1:0]    count_q, count_d;

  logic [PW-1:0]    ram_cnt_s;
  logic [PW-1:0]    ram_cnt_d;
  logic             pop_s;
  logic             wr_en_s;
  logic             a_load_s;
  logic             b_load_s;

  assign ram_cnt_s = wr_ptr_q - rd_ptr_q;

  // Next-state: pointer moves, stage loads, sticky flags and registered status.
  always_comb begin
    pop_s     = bus.o_read & b_v_q;
    wr_en_s   = 1'b0;
    a_load_s  = 1'b0;
    b_load_s  = 1'b0;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    a_v_d     = a_v_q;
    b_v_d     = b_v_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;

    if (bus.i_flush) begin
      // Flush wins over any write/read in the same cycle; no flags are set.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      a_v_d    = 1'b0;
      b_v_d    = 1'b0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      // Space is judged on the pre-edge RAM count; a same-cycle drain into A
      // does not make room for this cycle's write.
      wr_en_s  = bus.i_valid && (ram_cnt_s < DEPTH_C);
      a_load_s = (ram_cnt_s != '0) && (!a_v_q || !b_v_q || pop_s);
      b_load_s = a_v_q && (!b_v_q || pop_s);

      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (a_load_s) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        a_v_d    = 1'b1;
      end else if (b_load_s) begin
        a_v_d    = 1'b0;
      end else begin
        a_v_d    = a_v_q;
      end

      if (b_load_s) begin
        b_v_d = 1'b1;
      end else if (pop_s) begin
        b_v_d = 1'b0;
      end else begin
        b_v_d = b_v_q;
      end

      if (bus.i_valid && (ram_cnt_s == DEPTH_C)) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end

      if (bus.o_read && !b_v_q) begin
        unf_d = 1'b1;
      end else begin
        unf_d = unf_q;
      end
    end

    ram_cnt_d = wr_ptr_d - rd_ptr_d;
    count_d   = ram_cnt_d + PW'(a_v_d) + PW'(b_v_d);
    i_ready_d = (DEPTH_C - ram_cnt_d) > AF_C;
    ae_d      = {{(32-PW){1'b0}}, count_d} <= AE_C;
  end

  // Control and status registers; async reset leaves upstream not-ready.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      a_v_q     <= 1'b0;
      b_v_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      i_ready_q <= 1'b0;
      ae_q      <= 1'b1;
      count_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      a_v_q     <= a_v_d;
      b_v_q     <= b_v_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      i_ready_q <= i_ready_d;
      ae_q      <= ae_d;
      count_q   <= count_d;
    end
  end

  // Output data stages; flush leaves the last head word visible on o_data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_load_s) begin
        a_data_q <= mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
      end
      if (b_load_s) begin
        b_data_q <= a_data_q;
      end
    end
  end

  // Storage RAM write port; contents need no reset since valids gate them.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.i_data;
    end
  end

  assign bus.i_ready        = i_ready_q;
  assign bus.o_data         = b_data_q;
  assign bus.o_valid        = b_v_q;
  assign bus.o_almost_empty = ae_q;
  assign bus.o_count        = count_q;
  assign bus.o_overflow     = ovf_q;
  assign bus.o_underflow    = unf_q;

endmodule

// File: tb/tb_fwft_fifo_sync.sv
// Directed bench for fwft_fifo_sync with DEPTH=16, AF_MARGIN=4, AE_THRESH=15.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fwft_fifo_sync;

  localparam int NB = 16;
  localparam int DL = 4;
  localparam int AF = 4;
  localparam int AE = 15;

  logic clock = 1'b0;
  logic reset_n;

  always #5 clock = ~clock;

  fwft_fifo_sync_if #(.NBITS(NB), .DEPTH_LOG2(DL)) bus ();

  fwft_fifo_sync #(
    .NBITS(NB), .DEPTH_LOG2(DL), .AF_MARGIN(AF), .AE_THRESH(AE)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.o_read  = 1'b0;
    bus.i_flush = 1'b0;
  endtask

  initial begin
    int sent;
    int recv;
    int cycles;

    reset_n    = 1'b0;
    bus.i_data = '0;
    idle();
    @(negedge clock);
    @(negedge clock);

    // Reset state
    check_eq("rst i_ready", bus.i_ready, 32'd0);
    check_eq("rst ae", bus.o_almost_empty, 32'd1);
    check_eq("rst count", bus.o_count, 32'd0);
    check_eq("rst valid", bus.o_valid, 32'd0);
    check_eq("rst data", bus.o_data, 32'd0);
    check_eq("rst ovf", bus.o_overflow, 32'd0);
    check_eq("rst unf", bus.o_underflow, 32'd0);
    reset_n = 1'b1;
    #1;
    check_eq("i_ready before edge", bus.i_ready, 32'd0);
    tick();
    check_eq("i_ready after edge", bus.i_ready, 32'd1);

    // 1: single word latency
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h00A5;
    tick();
    bus.i_valid = 1'b0;
    check_eq("t1 count e0", bus.o_count, 32'd1);
    check_eq("t1 valid e0", bus.o_valid, 32'd0);
    tick();
    check_eq("t1 valid e1", bus.o_valid, 32'd0);
    tick();
    check_eq("t1 valid e2", bus.o_valid, 32'd1);
    check_eq("t1 data e2", bus.o_data, 32'h00A5);
    check_eq("t1 count e2", bus.o_count, 32'd1);
    check_eq("t1 ae e2", bus.o_almost_empty, 32'd1);
    bus.o_read = 1'b1;
    tick();
    bus.o_read = 1'b0;
    check_eq("t1 valid popped", bus.o_valid, 32'd0);
    check_eq("t1 count popped", bus.o_count, 32'd0);

    // 2: fill with 18 words, watch i_ready and almost-empty
    for (int k = 0; k < 18; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = NB'(k);
      tick();
      check_eq("t2 count", bus.o_count, 32'(k + 1));
      check_eq("t2 i_ready", bus.i_ready, (k + 1 < 14) ? 32'd1 : 32'd0);
      check_eq("t2 ae", bus.o_almost_empty, (k + 1 <= AE) ? 32'd1 : 32'd0);
    end
    bus.i_valid = 1'b0;
    check_eq("t2 ovf", bus.o_overflow, 32'd0);

    // 3: write into full FIFO is dropped, then drain in order
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0099;
    tick();
    bus.i_valid = 1'b0;
    check_eq("t3 ovf", bus.o_overflow, 32'd1);
    check_eq("t3 count", bus.o_count, 32'd18);
    for (int k = 0; k < 18; k++) begin
      check_eq("t3 drain valid", bus.o_valid, 32'd1);
      check_eq("t3 drain data", bus.o_data, 32'(k));
      bus.o_read = 1'b1;
      tick();
    end
    bus.o_read = 1'b0;
    check_eq("t3 empty valid", bus.o_valid, 32'd0);
    check_eq("t3 empty count", bus.o_count, 32'd0);
    check_eq("t3 ovf sticky", bus.o_overflow, 32'd1);
    check_eq("t3 unf", bus.o_underflow, 32'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check_eq("t3 ovf flushed", bus.o_overflow, 32'd0);

    // 4: streaming with random write gaps, crosses pointer wrap many times
    sent   = 0;
    recv   = 0;
    cycles = 0;
    while (recv < 1000 && cycles < 6000) begin
      if (bus.o_valid) begin
        check_eq("t4 data", bus.o_data, 32'(recv & 16'hFFFF));
        recv++;
      end
      bus.o_read = bus.o_valid;
      check_eq("t4 count<=3", 32'(bus.o_count <= 3), 32'd1);
      bus.i_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      bus.i_data  = NB'(sent);
      if (bus.i_valid) begin
        sent++;
      end
      tick();
      cycles++;
    end
    idle();
    check_eq("t4 received", 32'(recv), 32'd1000);
    check_eq("t4 ovf", bus.o_overflow, 32'd0);
    check_eq("t4 unf", bus.o_underflow, 32'd0);
    check_eq("t4 count end", bus.o_count, 32'd0);

    // 5: read while empty
    bus.o_read = 1'b1;
    tick();
    bus.o_read = 1'b0;
    check_eq("t5 unf", bus.o_underflow, 32'd1);
    check_eq("t5 count", bus.o_count, 32'd0);
    check_eq("t5 valid", bus.o_valid, 32'd0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    check_eq("t5 unf flushed", bus.o_underflow, 32'd0);

    // 6: flush with simultaneous write and read
    for (int k = 0; k < 10; k++) begin
      bus.i_valid = 1'b1;
      bus.i_data  = NB'(16'h0100 + k);
      tick();
    end
    bus.i_valid = 1'b0;
    tick();
    tick();
    check_eq("t6 count", bus.o_count, 32'd10);
    check_eq("t6 head", bus.o_data, 32'h0100);
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0055;
    bus.o_read  = 1'b1;
    tick();
    idle();
    check_eq("t6 valid", bus.o_valid, 32'd0);
    check_eq("t6 count0", bus.o_count, 32'd0);
    check_eq("t6 ovf", bus.o_overflow, 32'd0);
    check_eq("t6 unf", bus.o_underflow, 32'd0);
    check_eq("t6 data kept", bus.o_data, 32'h0100);
    check_eq("t6 ae", bus.o_almost_empty, 32'd1);
    check_eq("t6 i_ready", bus.i_ready, 32'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0077;
    tick();
    bus.i_valid = 1'b0;
    check_eq("t6 new count", bus.o_count, 32'd1);
    check_eq("t6 new valid e0", bus.o_valid, 32'd0);
    tick();
    check_eq("t6 new valid e1", bus.o_valid, 32'd0);
    tick();
    check_eq("t6 new valid e2", bus.o_valid, 32'd1);
    check_eq("t6 new data", bus.o_data, 32'h0077);

    // Reset mid-transfer clears immediately, no flags
    bus.i_valid = 1'b1;
    bus.i_data  = 16'h0033;
    tick();
    tick();
    reset_n = 1'b0;
    #1;
    check_eq("mrst count", bus.o_count, 32'd0);
    check_eq("mrst valid", bus.o_valid, 32'd0);
    check_eq("mrst data", bus.o_data, 32'd0);
    check_eq("mrst i_ready", bus.i_ready, 32'd0);
    check_eq("mrst ovf", bus.o_overflow, 32'd0);
    idle();
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    check_eq("mrst recover i_ready", bus.i_ready, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
